// File: rtl/bcd_to_bin.sv
// Sequential BCD-to-binary converter (reverse double-dabble, one bit per clock)
// with valid/ready handshakes, digit-error flag and saturating overflow flag.
module bcd_to_bin #(
    parameter int DIGITS = 5,
    parameter int BIN_W  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [4*DIGITS-1:0]   i_bcd,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [BIN_W-1:0]      o_bin,
    output logic                  o_ovf,
    output logic                  o_err
);

    localparam int W     = 4 * DIGITS;
    localparam int CNT_W = $clog2(W + 1);
    localparam int MAXW  = (W > BIN_W) ? W : BIN_W;
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(W - 1);
    localparam logic [MAXW-1:0]  BIN_MAX = MAXW'({BIN_W{1'b1}});

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]       bcd_q, bcd_d;
    logic [W-1:0]       acc_q, acc_d;
    logic               derr_q, derr_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic               ovf_q, ovf_d;
    logic               err_q, err_d;

    logic [W-1:0]       bcd_sh, bcd_adj, acc_sh;
    logic [MAXW-1:0]    acc_x;
    logic               in_err;

    always_comb begin
        {bcd_sh, acc_sh} = {bcd_q, acc_q} >> 1;
        // Undo the doubling correction: nibbles that borrowed a carry of 8 drop back by 3.
        bcd_adj = bcd_sh;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_sh[4*i +: 4] >= 4'd8) begin
                bcd_adj[4*i +: 4] = bcd_sh[4*i +: 4] - 4'd3;
            end
        end
        acc_x = MAXW'(acc_sh);

        in_err = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (i_bcd[4*i +: 4] > 4'd9) begin
                in_err = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        acc_d   = acc_q;
        derr_d  = derr_q;
        bin_d   = bin_q;
        ovf_d   = ovf_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    bcd_d   = i_bcd;
                    acc_d   = '0;
                    derr_d  = in_err;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                bcd_d = bcd_adj;
                acc_d = acc_sh;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    if (derr_q) begin
                        err_d = 1'b1;
                        ovf_d = 1'b0;
                        bin_d = '0;
                    end else if (acc_x > BIN_MAX) begin
                        err_d = 1'b0;
                        ovf_d = 1'b1;
                        bin_d = '1;
                    end else begin
                        err_d = 1'b0;
                        ovf_d = 1'b0;
                        bin_d = acc_x[BIN_W-1:0];
                    end
                end
            end
            DONE: begin
                if (i_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bcd_q   <= '0;
            acc_q   <= '0;
            derr_q  <= 1'b0;
            bin_q   <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            acc_q   <= acc_d;
            derr_q  <= derr_d;
            bin_q   <= bin_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

    assign o_ready = (state_q == IDLE);
    assign o_valid = (state_q == DONE);
    assign o_bin   = bin_q;
    assign o_ovf   = ovf_q;
    assign o_err   = err_q;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed bench for bcd_to_bin: decimal-arithmetic reference model, per-cycle
// compare process, and literal expectations for each vector.
module tb_bcd_to_bin;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [19:0] i_bcd = '0;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [15:0] o_bin;
    logic        o_ovf;
    logic        o_err;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_bin = '0;
    logic        exp_ovf = 1'b0;
    logic        exp_err = 1'b0;

    bcd_to_bin #(.DIGITS(5), .BIN_W(16)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_bcd   (i_bcd),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_bin   (o_bin),
        .o_ovf   (o_ovf),
        .o_err   (o_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Decimal interpretation of the digit word, then range/error rules.
    function automatic void model(input logic [19:0] w, output logic [15:0] b,
                                  output logic ovf, output logic err);
        int v;
        v = 0;
        err = 1'b0;
        for (int i = 4; i >= 0; i--) begin
            int d;
            d = int'(w[i*4 +: 4]);
            if (d > 9) err = 1'b1;
            v = v * 10 + d;
        end
        if (err) begin
            b = 16'h0; ovf = 1'b0;
        end else if (v > 65535) begin
            b = 16'hFFFF; ovf = 1'b1;
        end else begin
            b = 16'(v); ovf = 1'b0;
        end
    endfunction

    always @(negedge i_clk) begin
        if (!i_rst) begin
            chk("ready_valid_exclusive", {31'd0, o_ready & o_valid}, 32'd0);
            if (o_valid) begin
                chk("cmp_bin", {16'd0, o_bin}, {16'd0, exp_bin});
                chk("cmp_ovf", {31'd0, o_ovf}, {31'd0, exp_ovf});
                chk("cmp_err", {31'd0, o_err}, {31'd0, exp_err});
            end
        end
    end

    task automatic accept(input logic [19:0] w);
        int n;
        logic [15:0] mb;
        logic mo, me;
        n = 0;
        while (!o_ready && n < 100) begin
            @(posedge i_clk); #1; n++;
        end
        chk("ready_before_accept", {31'd0, o_ready}, 32'd1);
        model(w, mb, mo, me);
        exp_bin = mb; exp_ovf = mo; exp_err = me;
        i_valid = 1'b1;
        i_bcd   = w;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        i_bcd   = 20'($urandom);
    endtask

    task automatic convert(input logic [19:0] w, input logic [15:0] eb, input logic eo,
                           input logic ee, input int hold);
        int n;
        logic [15:0] mb;
        logic mo, me;
        model(w, mb, mo, me);
        chk("model_bin", {16'd0, mb}, {16'd0, eb});
        chk("model_flags", {30'd0, mo, me}, {30'd0, eo, ee});
        accept(w);
        n = 0;
        do begin
            @(posedge i_clk); #1; n++;
        end while (!o_valid && n < 100);
        chk("latency", n, 32'd20);
        chk("bin", {16'd0, o_bin}, {16'd0, eb});
        chk("ovf", {31'd0, o_ovf}, {31'd0, eo});
        chk("err", {31'd0, o_err}, {31'd0, ee});
        for (int k = 0; k < hold; k++) begin
            i_valid = 1'($urandom);
            i_bcd   = 20'($urandom);
            @(posedge i_clk); #1;
            chk("hold_valid", {31'd0, o_valid}, 32'd1);
            chk("hold_ready", {31'd0, o_ready}, 32'd0);
            chk("hold_bin", {16'd0, o_bin}, {16'd0, eb});
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        i_ready = 1'b0;
        chk("handoff_valid", {31'd0, o_valid}, 32'd0);
        chk("handoff_ready", {31'd0, o_ready}, 32'd1);
        chk("handoff_bin_kept", {16'd0, o_bin}, {16'd0, eb});
        chk("handoff_flags_kept", {30'd0, o_ovf, o_err}, {30'd0, eo, ee});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("rst_ready", {31'd0, o_ready}, 32'd1);
        chk("rst_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_outs", {14'd0, o_bin, o_ovf, o_err}, 32'd0);
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        @(posedge i_clk); #1;

        convert(20'h00000, 16'h0000, 1'b0, 1'b0, 0);
        convert(20'h12345, 16'h3039, 1'b0, 1'b0, 1);
        convert(20'h65535, 16'hFFFF, 1'b0, 1'b0, 0);
        convert(20'h65536, 16'hFFFF, 1'b1, 1'b0, 0);
        convert(20'h99999, 16'hFFFF, 1'b1, 1'b0, 2);
        convert(20'h0A123, 16'h0000, 1'b0, 1'b1, 0);
        convert(20'h0000F, 16'h0000, 1'b0, 1'b1, 0);
        convert(20'h00099, 16'h0063, 1'b0, 1'b0, 10);
        convert(20'h00042, 16'h002A, 1'b0, 1'b0, 0);

        // Abort a conversion mid-shift with an asynchronous reset.
        accept(20'h54321);
        repeat (6) begin
            @(posedge i_clk); #1;
        end
        i_rst = 1'b1;
        #1;
        chk("abort_valid", {31'd0, o_valid}, 32'd0);
        chk("abort_ready", {31'd0, o_ready}, 32'd1);
        chk("abort_outs", {14'd0, o_bin, o_ovf, o_err}, 32'd0);
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        repeat (25) begin
            @(posedge i_clk); #1;
            chk("post_abort_idle", {30'd0, o_ready, o_valid}, 32'd2);
        end
        convert(20'h00100, 16'h0064, 1'b0, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
